gb_instr_sequencer: RTL and testbench

Program-buffer sequencer that drives the gbprocessor instruction stream (instruction, data, valid). A host loads up to DEPTH instruction/data pairs, sets a length and an inter-instruction gap, then pulses start. The block issues the program one entry per valid cycle, waits for the last register write to land, and captures the processor's 64-bit probe as the run result.

---
 rtl/gb_instr_sequencer_if.sv | 32 +++
 rtl/gb_instr_sequencer.sv | 176 +++++++++++++++++
 tb/tb_gb_instr_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_instr_sequencer_if.sv
// Host/processor-side bundle of the gbprocessor program-buffer sequencer.
// The master is the sequencer (drives the instruction stream); the slave is the host/processor side.
interface gb_instr_sequencer_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_instr;
  logic [7:0]    wr_data;
  logic [AW:0]   prog_len;
  logic [3:0]    gap;
  logic          start;
  logic          abort;
  logic [63:0]   probe;
  logic [7:0]    instruction;
  logic [7:0]    data;
  logic          valid;
  logic          busy;
  logic          done;
  logic [63:0]   result;
  logic [AW:0]   issue_cnt;

  modport master (
    input  wr_en, wr_addr, wr_instr, wr_data, prog_len, gap, start, abort, probe,
    output instruction, data, valid, busy, done, result, issue_cnt
  );

  modport slave (
    output wr_en, wr_addr, wr_instr, wr_data, prog_len, gap, start, abort, probe,
    input  instruction, data, valid, busy, done, result, issue_cnt
  );
endinterface

// File: rtl/gb_instr_sequencer.sv
// Program-buffer sequencer: replays stored {instruction,data} pairs to the gbprocessor
// with a programmable gap, then captures the register probe once the last write lands.
module gb_instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic                  clock,
  input logic                  reset,
  gb_instr_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = '0;

  logic [15:0]   mem_r [DEPTH];
  state_t        state_r;
  logic [AW:0]   len_r;
  logic [3:0]    gap_r;
  logic [3:0]    gap_cnt_r;
  logic [AW-1:0] ptr_r;
  logic [7:0]    instr_r;
  logic [7:0]    data_r;
  logic          valid_r;
  logic          busy_r;
  logic          done_r;
  logic [63:0]   result_r;
  logic [AW:0]   issue_cnt_r;

  logic [AW:0]   len_clamp_s;
  logic          last_s;
  logic [AW-1:0] ptr_next_s;
  logic [15:0]   entry_s;
  logic [15:0]   next_entry_s;
  logic [AW:0]   cnt_next_s;

  // Run-length clamp, last-entry detect and buffer read ports.
  always_comb begin
    len_clamp_s = bus.prog_len;
    if (bus.prog_len > DEPTH_W) begin
      len_clamp_s = DEPTH_W;
    end else begin
      len_clamp_s = bus.prog_len;
    end
    last_s       = ({1'b0, ptr_r} == (len_r - (AW+1)'(1)));
    ptr_next_s   = ptr_r + AW'(1);
    entry_s      = mem_r[ptr_r];
    next_entry_s = mem_r[ptr_next_s];
    cnt_next_s   = issue_cnt_r;
    if (issue_cnt_r != len_r) begin
      cnt_next_s = issue_cnt_r + (AW+1)'(1);
    end else begin
      cnt_next_s = issue_cnt_r;
    end
  end

  // Program buffer: host writes only while the sequencer is idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (bus.wr_en && !busy_r) begin
      mem_r[bus.wr_addr] <= {bus.wr_instr, bus.wr_data};
    end
  end

  // Sequencer FSM; the output registers load on the edge that enters ISSUE so valid lines up with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      len_r       <= '0;
      gap_r       <= 4'd0;
      gap_cnt_r   <= 4'd0;
      ptr_r       <= '0;
      instr_r     <= 8'h00;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= 64'h0;
      issue_cnt_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start && !bus.abort && (bus.prog_len != (AW+1)'(0))) begin
            len_r       <= len_clamp_s;
            gap_r       <= bus.gap;
            ptr_r       <= PTR_ZERO;
            issue_cnt_r <= '0;
            busy_r      <= 1'b1;
            valid_r     <= 1'b1;
            instr_r     <= mem_r[PTR_ZERO][15:8];
            data_r      <= mem_r[PTR_ZERO][7:0];
            state_r     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.abort) begin
            state_r <= S_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            instr_r <= 8'h00;
            data_r  <= 8'h00;
          end else begin
            issue_cnt_r <= cnt_next_s;
            if (last_s) begin
              state_r <= S_DRAIN;
              valid_r <= 1'b0;
              instr_r <= 8'h00;
              data_r  <= 8'h00;
            end else begin
              ptr_r <= ptr_next_s;
              if (gap_r != 4'd0) begin
                state_r   <= S_GAP;
                gap_cnt_r <= gap_r;
                valid_r   <= 1'b0;
                instr_r   <= 8'h00;
                data_r    <= 8'h00;
              end else begin
                valid_r <= 1'b1;
                instr_r <= next_entry_s[15:8];
                data_r  <= next_entry_s[7:0];
              end
            end
          end
        end
        S_GAP: begin
          if (bus.abort) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else if (gap_cnt_r == 4'd1) begin
            state_r <= S_ISSUE;
            valid_r <= 1'b1;
            instr_r <= entry_s[15:8];
            data_r  <= entry_s[7:0];
          end else begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
          end
        end
        S_DRAIN: begin
          // The processor has retired the final write by now, so the probe is stable.
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          if (!bus.abort) begin
            result_r <= bus.probe;
            done_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          instr_r <= 8'h00;
          data_r  <= 8'h00;
        end
      endcase
    end
  end

  assign bus.instruction = instr_r;
  assign bus.data        = data_r;
  assign bus.valid       = valid_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result      = result_r;
  assign bus.issue_cnt   = issue_cnt_r;

endmodule

// File: tb/tb_gb_instr_sequencer.sv
// Scoreboard bench for gb_instr_sequencer: stimulus queues expected issues, completions and
// status samples by cycle; a negedge monitor pops and compares them against the DUT.
module tb_gb_instr_sequencer;

  localparam int KIND_BUSY = 0;
  localparam int KIND_CNT  = 1;
  localparam int KIND_RES  = 2;

  localparam logic [63:0] PA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PB = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] PC = 64'h5A5A_0F0F_A5A5_F0F0;

  typedef struct { int cyc; logic [7:0] instr; logic [7:0] data; } iss_t;
  typedef struct { int cyc; logic [63:0] res; } done_t;
  typedef struct { int cyc; int kind; logic [63:0] val; } chk_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  iss_t  iss_q[$];
  done_t done_q[$];
  chk_t  chk_q[$];
  logic [15:0] tb_mem [16];

  gb_instr_sequencer_if #(.AW(4)) bus ();

  gb_instr_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every issue, completion and queued status sample at the falling edge.
  initial begin : monitor
    iss_t        e;
    done_t       d;
    chk_t        c;
    logic [63:0] act;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (bus.valid) begin
          total++;
          if (iss_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid cyc=%0d got=%h/%h required=no issue", cyc, bus.instruction, bus.data);
          end else begin
            e = iss_q.pop_front();
            if (cyc != e.cyc || bus.instruction != e.instr || bus.data != e.data) begin
              bad++;
              $display("FAIL issue got cyc=%0d %h/%h required cyc=%0d %h/%h",
                       cyc, bus.instruction, bus.data, e.cyc, e.instr, e.data);
            end
          end
        end else begin
          total++;
          if (bus.instruction != 8'h00 || bus.data != 8'h00) begin
            bad++;
            $display("FAIL idle_bus cyc=%0d got=%h/%h required=00/00", cyc, bus.instruction, bus.data);
          end
        end
        if (bus.done) begin
          total++;
          if (done_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done cyc=%0d result=%h required=no done", cyc, bus.result);
          end else begin
            d = done_q.pop_front();
            if (cyc != d.cyc || bus.result != d.res) begin
              bad++;
              $display("FAIL done got cyc=%0d result=%h required cyc=%0d result=%h", cyc, bus.result, d.cyc, d.res);
            end
          end
        end
        while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
          e = iss_q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_issue got=none required cyc=%0d %h/%h", e.cyc, e.instr, e.data);
        end
        while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
          d = done_q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_done got=none required cyc=%0d result=%h", d.cyc, d.res);
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
          c = chk_q.pop_front();
          case (c.kind)
            KIND_BUSY: act = {63'd0, bus.busy};
            KIND_CNT:  act = 64'(bus.issue_cnt);
            KIND_RES:  act = bus.result;
            default:   act = '1;
          endcase
          total++;
          if (act != c.val) begin
            bad++;
            $display("FAIL status kind=%0d cyc=%0d got=%h required=%h", c.kind, cyc, act, c.val);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic push_chk(input int at, input int kind, input logic [63:0] val);
    chk_t c;
    c.cyc = at; c.kind = kind; c.val = val;
    chk_q.push_back(c);
  endtask

  task automatic host_write(input int a, input logic [7:0] i, input logic [7:0] d, input bit stored);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 4'(a);
    bus.wr_instr = i;
    bus.wr_data  = d;
    tick();
    bus.wr_en = 1'b0;
    if (stored) tb_mem[a] = {i, d};
  endtask

  task automatic start_run(input int plen, input int g, input bit with_abort, output int t);
    bus.prog_len = 5'(plen);
    bus.gap      = 4'(g);
    bus.start    = 1'b1;
    bus.abort    = with_abort;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    t = cyc;
  endtask

  task automatic expect_issues(input int t, input int g, input int n);
    iss_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc   = t + k * (g + 1);
      e.instr = tb_mem[k][15:8];
      e.data  = tb_mem[k][7:0];
      iss_q.push_back(e);
    end
  endtask

  task automatic expect_done(input int t, input int l, input int g, input logic [63:0] r);
    done_t d;
    d.cyc = t + (l - 1) * (g + 1) + 2;
    d.res = r;
    done_q.push_back(d);
    push_chk(t, KIND_BUSY, 64'd1);
    push_chk(d.cyc, KIND_BUSY, 64'd0);
    push_chk(d.cyc, KIND_CNT, 64'(l));
    push_chk(d.cyc, KIND_RES, r);
  endtask

  initial begin : stimulus
    int t;
    for (int i = 0; i < 16; i++) tb_mem[i] = 16'h0000;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_instr = 8'h00; bus.wr_data = 8'h00;
    bus.prog_len = 5'd0; bus.gap = 4'd0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.probe = PA;
    wait_cycles(3);
    reset = 1'b0;
    mon_en = 1'b1;
    push_chk(cyc, KIND_BUSY, 64'd0);
    push_chk(cyc, KIND_RES, 64'd0);
    push_chk(cyc, KIND_CNT, 64'd0);

    host_write(0, 8'h80, 8'h11, 1'b1);
    host_write(1, 8'h88, 8'h22, 1'b1);
    host_write(2, 8'h90, 8'h33, 1'b1);
    host_write(3, 8'h98, 8'h44, 1'b1);

    // Back-to-back program, gap 0.
    start_run(4, 0, 1'b0, t);
    expect_issues(t, 0, 4);
    expect_done(t, 4, 0, PA);
    wait_cycles(8);

    // Same program with gap 3.
    bus.probe = PB;
    start_run(4, 3, 1'b0, t);
    expect_issues(t, 3, 4);
    expect_done(t, 4, 3, PB);
    wait_cycles(18);

    // Zero-length start is ignored.
    start_run(0, 0, 1'b0, t);
    push_chk(t, KIND_BUSY, 64'd0);
    wait_cycles(5);

    // Oversized length clamps to the full buffer.
    for (int i = 4; i < 16; i++) host_write(i, 8'(8'hC0 + i), 8'(i * 3), 1'b1);
    bus.probe = PC;
    start_run(20, 0, 1'b0, t);
    expect_issues(t, 0, 16);
    expect_done(t, 16, 0, PC);
    wait_cycles(20);

    // Abort during the gap after the second issue.
    bus.probe = PA;
    start_run(4, 3, 1'b0, t);
    expect_issues(t, 3, 2);
    wait_cycles(5);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    push_chk(t + 6, KIND_BUSY, 64'd0);
    push_chk(t + 6, KIND_CNT, 64'd2);
    push_chk(t + 6, KIND_RES, PC);
    wait_cycles(12);
    push_chk(cyc, KIND_RES, PC);
    tick();
    start_run(4, 0, 1'b0, t);
    expect_issues(t, 0, 4);
    expect_done(t, 4, 0, PA);
    wait_cycles(8);

    // Host write while busy must not reach the buffer.
    bus.probe = PB;
    start_run(4, 1, 1'b0, t);
    expect_issues(t, 1, 4);
    expect_done(t, 4, 1, PB);
    host_write(0, 8'hFF, 8'hEE, 1'b0);
    wait_cycles(10);
    start_run(1, 0, 1'b0, t);
    expect_issues(t, 0, 1);
    expect_done(t, 1, 0, PB);
    wait_cycles(5);

    // Start and abort together in IDLE: no run.
    start_run(4, 0, 1'b1, t);
    push_chk(t, KIND_BUSY, 64'd0);
    wait_cycles(6);

    // Reset in the middle of an issue run clears everything, buffer included.
    bus.probe = PC;
    start_run(4, 0, 1'b0, t);
    expect_issues(t, 0, 2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) tb_mem[i] = 16'h0000;
    push_chk(t + 2, KIND_BUSY, 64'd0);
    push_chk(t + 2, KIND_RES, 64'd0);
    push_chk(t + 2, KIND_CNT, 64'd0);
    start_run(1, 0, 1'b0, t);
    expect_issues(t, 0, 1);
    expect_done(t, 1, 0, PC);
    wait_cycles(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
